// File: rtl/pulse_interval_meter.sv
// Interval meter: counts clk edges from a sampled start to a sampled stop.
// A new result comes with a one-cycle count_valid. An interval that reaches TIMEOUT is dropped with a one-cycle timeout strobe.
module pulse_interval_meter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         stop,
  input  logic         abort,
  output logic         busy,
  output logic [W-1:0] count,
  output logic         count_valid,
  output logic         timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

  state_t       state;
  logic [W-1:0] counter;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      counter     <= '0;
      busy        <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks start; stop is meaningless with nothing to end
          if (start && !abort) begin
            state   <= MEASURE;
            busy    <= 1'b1;
            counter <= W'(1);
          end
        end
        MEASURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (stop) begin
            count       <= counter;
            count_valid <= 1'b1;
            // start with stop chains straight into the next measurement
            if (start) begin
              counter <= W'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (counter == TIMEOUT_W) begin
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            counter <= counter + W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
